// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges never-stalled load returns with queued ALU results
// onto the single register-file write port, and tracks pending destinations.
module wb_arbiter #(
  parameter int W     = 8,
  parameter int A     = 3,
  parameter int DEPTH = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AluValid,
  output logic              AluReady,
  input  logic [A-1:0]      AluAddr,
  input  logic [W-1:0]      AluData,
  input  logic              LoadValid,
  input  logic [A-1:0]      LoadAddr,
  input  logic [W-1:0]      LoadData,
  output logic              RfWriteEn,
  output logic [A-1:0]      RfWaddr,
  output logic [W-1:0]      RfDataIn,
  output logic [2**A-1:0]   PendingMask,
  output logic              Conflict
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NR = 2 ** A;

  // ALU handshake: a result transfers on a rising edge where AluValid && AluReady.
  // AluReady depends only on the occupancy count, never on this cycle's dequeue.

  logic [A-1:0]     q_addr_q [DEPTH];
  logic [A-1:0]     q_addr_d [DEPTH];
  logic [W-1:0]     q_data_q [DEPTH];
  logic [W-1:0]     q_data_d [DEPTH];
  logic [DEPTH-1:0] q_valid_q, q_valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic             rf_we_q, rf_we_d;
  logic [A-1:0]     rf_waddr_q, rf_waddr_d;
  logic [W-1:0]     rf_wdata_q, rf_wdata_d;
  logic             conflict_q, conflict_d;

  logic             alu_fire;
  logic             enq;
  logic             deq;
  logic [NR-1:0]    pending;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign AluReady = (count_q < CW'(DEPTH));
  assign alu_fire = AluValid && AluReady;

  // Valid slots plus the write currently being presented to the register file.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid_q[i]) begin
        pending[q_addr_q[i]] = 1'b1;
      end
    end
    if (rf_we_q) begin
      pending[rf_waddr_q] = 1'b1;
    end
  end

  assign PendingMask = pending;

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    enq        = 1'b0;
    deq        = 1'b0;
    if (LoadValid) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = LoadAddr;
      rf_wdata_d = LoadData;
      enq        = alu_fire;
    end else if (count_q != '0) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = q_addr_q[head_q];
      rf_wdata_d = q_data_q[head_q];
      deq        = 1'b1;
      enq        = alu_fire;
    end else if (alu_fire) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = AluAddr;
      rf_wdata_d = AluData;
    end
  end

  always_comb begin
    q_addr_d  = q_addr_q;
    q_data_d  = q_data_q;
    q_valid_d = q_valid_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (deq) begin
      q_valid_d[head_q] = 1'b0;
      head_d            = next_ptr(head_q);
    end
    // Enqueue only happens when not full, so tail never collides with head here.
    if (enq) begin
      q_valid_d[tail_q] = 1'b1;
      q_addr_d[tail_q]  = AluAddr;
      q_data_d[tail_q]  = AluData;
      tail_d            = next_ptr(tail_q);
    end
    count_d = count_q + CW'(enq) - CW'(deq);
  end

  always_comb begin
    conflict_d = (alu_fire && pending[AluAddr])
              || (LoadValid && pending[LoadAddr])
              || (alu_fire && LoadValid && (AluAddr == LoadAddr));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_valid_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      conflict_q <= 1'b0;
    end else begin
      q_valid_q  <= q_valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      conflict_q <= conflict_d;
    end
  end

  // Payload storage needs no reset: slot contents are only read when valid.
  always_ff @(posedge Clk) begin
    q_addr_q <= q_addr_d;
    q_data_q <= q_data_d;
  end

  assign RfWriteEn = rf_we_q;
  assign RfWaddr   = rf_waddr_q;
  assign RfDataIn  = rf_wdata_q;
  assign Conflict  = conflict_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, checked per cycle
// against a queue-based model of the writeback rules.
module tb_wb_arbiter;

  localparam int W     = 8;
  localparam int A     = 3;
  localparam int DEPTH = 2;
  localparam int NR    = 2 ** A;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          AluValid;
  logic          AluReady;
  logic [A-1:0]  AluAddr;
  logic [W-1:0]  AluData;
  logic          LoadValid;
  logic [A-1:0]  LoadAddr;
  logic [W-1:0]  LoadData;
  logic          RfWriteEn;
  logic [A-1:0]  RfWaddr;
  logic [W-1:0]  RfDataIn;
  logic [NR-1:0] PendingMask;
  logic          Conflict;

  wb_arbiter #(.W(W), .A(A), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .AluValid(AluValid), .AluReady(AluReady), .AluAddr(AluAddr), .AluData(AluData),
    .LoadValid(LoadValid), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .RfWriteEn(RfWriteEn), .RfWaddr(RfWaddr), .RfDataIn(RfDataIn),
    .PendingMask(PendingMask), .Conflict(Conflict)
  );

  // Clock / reset block
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic          we;
    logic [A-1:0]  addr;
    logic [W-1:0]  data;
    logic [NR-1:0] mask;
    logic          conflict;
    logic          ready;
  } exp_t;

  typedef struct {
    logic [A-1:0] a;
    logic [W-1:0] d;
  } ent_t;

  // Reference model state: queued ALU results and the last presented write.
  ent_t         m_fifo[$];
  logic         m_we   = 1'b0;
  logic [A-1:0] m_addr = '0;
  logic [W-1:0] m_data = '0;
  logic         m_conf = 1'b0;
  logic         m_acc  = 1'b0;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  function automatic logic [NR-1:0] model_mask();
    logic [NR-1:0] m;
    m = '0;
    foreach (m_fifo[i]) m[m_fifo[i].a] = 1'b1;
    if (m_we) m[m_addr] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model, queue the expected outputs.
  task automatic step(input logic r, input logic lv, input logic [A-1:0] la,
                      input logic [W-1:0] ld, input logic av, input logic [A-1:0] aa,
                      input logic [W-1:0] ad);
    logic [NR-1:0] pm;
    ent_t e;
    exp_t x;
    Reset = r; LoadValid = lv; LoadAddr = la; LoadData = ld;
    AluValid = av; AluAddr = aa; AluData = ad;
    if (r) begin
      m_fifo.delete();
      m_we = 1'b0; m_addr = '0; m_data = '0; m_conf = 1'b0; m_acc = 1'b0;
    end else begin
      pm     = model_mask();
      m_acc  = av && (m_fifo.size() < DEPTH);
      m_conf = (m_acc && pm[aa]) || (lv && pm[la]) || (m_acc && lv && (aa == la));
      e.a = aa; e.d = ad;
      if (lv) begin
        m_we = 1'b1; m_addr = la; m_data = ld;
        if (m_acc) m_fifo.push_back(e);
      end else if (m_fifo.size() > 0) begin
        m_we = 1'b1; m_addr = m_fifo[0].a; m_data = m_fifo[0].d;
        void'(m_fifo.pop_front());
        if (m_acc) m_fifo.push_back(e);
      end else if (m_acc) begin
        m_we = 1'b1; m_addr = aa; m_data = ad;
      end else begin
        m_we = 1'b0;
      end
    end
    x.we = m_we; x.addr = m_addr; x.data = m_data; x.mask = model_mask();
    x.conflict = m_conf; x.ready = (m_fifo.size() < DEPTH);
    exp_q.push_back(x);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Hold an ALU offer until the model accepts it; the load is only offered once.
  task automatic offer(input logic lv, input logic [A-1:0] la, input logic [W-1:0] ld,
                       input logic [A-1:0] aa, input logic [W-1:0] ad);
    int tries;
    tries = 0;
    step(1'b0, lv, la, ld, 1'b1, aa, ad);
    while (!m_acc && tries < 20) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, aa, ad);
      tries++;
    end
    chk("offer_accepted", 32'(m_acc), 32'd1);
  endtask

  // Scoreboard monitor: compares every presented output cycle to the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_write_en",  32'(RfWriteEn),   32'(e.we));
        chk("rf_waddr",     32'(RfWaddr),     32'(e.addr));
        chk("rf_data_in",   32'(RfDataIn),    32'(e.data));
        chk("pending_mask", 32'(PendingMask), 32'(e.mask));
        chk("conflict",     32'(Conflict),    32'(e.conflict));
        chk("alu_ready",    32'(AluReady),    32'(e.ready));
      end
    end
  end

  initial begin
    logic r, lv, av;
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);

    // Bypass write
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd3, 8'h5A);
    idle(2);

    // Load and ALU in the same cycle
    step(1'b0, 1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
    idle(2);

    // Loads held while ALU fills the queue
    step(1'b0, 1'b1, 3'd4, 8'h44, 1'b1, 3'd0, 8'h00);
    step(1'b0, 1'b1, 3'd5, 8'h55, 1'b1, 3'd1, 8'h01);
    step(1'b0, 1'b1, 3'd6, 8'h66, 1'b1, 3'd2, 8'h02);
    offer(1'b0, '0, '0, 3'd2, 8'h02);
    idle(4);

    // Back-to-back writes to the same register
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd7, 8'hAA);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd7, 8'hBB);
    idle(3);

    // Reset with two queued entries, overriding same-cycle offers
    step(1'b0, 1'b1, 3'd5, 8'hC5, 1'b1, 3'd1, 8'hD1);
    step(1'b0, 1'b1, 3'd6, 8'hC6, 1'b1, 3'd2, 8'hD2);
    step(1'b1, 1'b1, 3'd3, 8'hC3, 1'b1, 3'd4, 8'hD4);
    idle(4);

    // Queue wrap: six ALU transfers interleaved with three loads
    for (int k = 0; k < 6; k++) begin
      offer((k % 2) == 0, 3'(k + 1), 8'(8'hE0 + k), 3'(k), 8'(8'h60 + k));
    end
    idle(6);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      lv = ($urandom_range(0, 2) == 0);
      av = ($urandom_range(0, 3) != 0);
      step(r, lv, 3'($urandom_range(0, NR - 1)), 8'($urandom_range(0, 255)),
           av, 3'($urandom_range(0, NR - 1)), 8'($urandom_range(0, 255)));
    end
    idle(6);

    @(posedge Clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
